// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute control sequencer for the 4-bit-opcode CPU, with stack-occupancy traps.
// Optional single-step PAUSE state is compiled in with `define INSTR_SEQUENCER_SINGLE_STEP_EN.
module instr_sequencer #(
    parameter int STACK_DEPTH = 8,
    parameter int CW          = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [13:0] dec,
    input  logic        gt_flag,
    input  logic        in_valid,
    input  logic        out_ready,
    output logic        dec_en,
    output logic        ir_ld,
    output logic        mem_rd,
    output logic        pc_inc,
    output logic        pc_ld,
    output logic        imm_ld,
    output logic        reg_we,
    output logic        alu_go,
    output logic        alu_sub,
    output logic        sp_push,
    output logic        sp_pop,
    output logic        in_ack,
    output logic        out_stb,
    output logic        halted,
    output logic        fault,
    output logic [2:0]  state
);

    localparam int B_MOVA = 0,  B_MOVD = 3,  B_ADD  = 4,  B_SUB  = 5;
    localparam int B_JMP  = 6,  B_JG   = 7,  B_IN1  = 8,  B_OUT1 = 9;
    localparam int B_MOVI = 10, B_HALT = 11, B_PUSH = 12, B_POP  = 13;

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    localparam int SW = 4;
    typedef enum logic [SW-1:0] {
        S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC = 4'd3,
        S_IMM  = 4'd4, S_WAIT_IO = 4'd5, S_HALT = 4'd6, S_FAULT = 4'd7,
        S_PAUSE = 4'd8
    } state_t;
    localparam state_t S_NEXT = S_PAUSE;
`else
    localparam int SW = 3;
    typedef enum logic [SW-1:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_IMM  = 3'd4, S_WAIT_IO = 3'd5, S_HALT = 3'd6, S_FAULT = 3'd7
    } state_t;
    localparam state_t S_NEXT = S_FETCH;
`endif

    state_t          state_q, state_d;
    logic [13:0]     op_q, op_d;
    logic [CW-1:0]   depth_q, depth_d;
    logic            multi_hot;

    // A decode word with more than one line set is illegal.
    assign multi_hot = |(dec & (dec - 14'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            depth_q <= depth_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        depth_d = depth_q;
        dec_en  = 1'b0;
        ir_ld   = 1'b0;
        mem_rd  = 1'b0;
        pc_inc  = 1'b0;
        pc_ld   = 1'b0;
        imm_ld  = 1'b0;
        reg_we  = 1'b0;
        alu_go  = 1'b0;
        alu_sub = 1'b0;
        sp_push = 1'b0;
        sp_pop  = 1'b0;
        in_ack  = 1'b0;
        out_stb = 1'b0;
        halted  = 1'b0;
        fault   = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: begin
                mem_rd  = 1'b1;
                ir_ld   = 1'b1;
                pc_inc  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                dec_en = 1'b1;
                op_d   = dec;
                if (dec == 14'd0)
                    state_d = S_NEXT;
                else if (multi_hot)
                    state_d = S_FAULT;
                else if (dec[B_PUSH])
                    state_d = (depth_q == CW'(STACK_DEPTH)) ? S_FAULT : S_EXEC;
                else if (dec[B_POP])
                    state_d = (depth_q == '0) ? S_FAULT : S_EXEC;
                else if (dec[B_HALT])
                    state_d = S_HALT;
                else if (dec[B_IN1] || dec[B_OUT1])
                    state_d = S_WAIT_IO;
                else if (dec[B_MOVI] || dec[B_JMP] || dec[B_JG])
                    state_d = S_IMM;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_NEXT;
                if (|op_q[B_MOVD:B_MOVA]) reg_we = 1'b1;
                if (op_q[B_ADD] || op_q[B_SUB]) begin
                    reg_we  = 1'b1;
                    alu_go  = 1'b1;
                    alu_sub = op_q[B_SUB];
                end
                if (op_q[B_PUSH]) begin
                    sp_push = 1'b1;
                    depth_d = depth_q + CW'(1);
                end
                if (op_q[B_POP]) begin
                    sp_pop  = 1'b1;
                    reg_we  = 1'b1;
                    depth_d = depth_q - CW'(1);
                end
            end
            S_IMM: begin
                mem_rd  = 1'b1;
                state_d = S_NEXT;
                if (op_q[B_MOVI]) begin
                    imm_ld = 1'b1;
                    reg_we = 1'b1;
                    pc_inc = 1'b1;
                end
                if (op_q[B_JMP]) pc_ld = 1'b1;
                if (op_q[B_JG]) begin
                    pc_ld  = gt_flag;
                    pc_inc = ~gt_flag;
                end
            end
            S_WAIT_IO: begin
                if (op_q[B_IN1]) begin
                    if (in_valid) begin
                        in_ack  = 1'b1;
                        reg_we  = 1'b1;
                        state_d = S_NEXT;
                    end
                end else if (op_q[B_OUT1]) begin
                    out_stb = 1'b1;
                    if (out_ready) state_d = S_NEXT;
                end
            end
            S_HALT: begin
                halted = op_q[B_HALT];
                if (start) state_d = S_FETCH;
            end
            S_FAULT: fault = 1'b1;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
            S_PAUSE: if (step) state_d = S_FETCH;
`endif
            default: state_d = S_IDLE;
        endcase
        // Nothing strobes while reset is held, even if the register still shows a busy state.
        if (rst) begin
            dec_en  = 1'b0;
            ir_ld   = 1'b0;
            mem_rd  = 1'b0;
            pc_inc  = 1'b0;
            pc_ld   = 1'b0;
            imm_ld  = 1'b0;
            reg_we  = 1'b0;
            alu_go  = 1'b0;
            alu_sub = 1'b0;
            sp_push = 1'b0;
            sp_pop  = 1'b0;
            in_ack  = 1'b0;
            out_stb = 1'b0;
            halted  = 1'b0;
            fault   = 1'b0;
        end
    end

    assign state = rst ? 3'd0 : state_q[2:0];

endmodule
